// File: rtl/mesh_output_arbiter_if.sv
// Link bundle between the per-input FIFOs, the output arbiter and the downstream router.
// The arbiter uses the master modport; the FIFO/link side uses slave.
interface mesh_output_arbiter_if #(
    parameter int N_IN    = 5,
    parameter int CREDITS = 8,
    parameter int FLIT_W  = 32
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int GW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef logic [FLIT_W-1:0] flit_t;

    flit_t [N_IN-1:0] in_flit;
    logic  [N_IN-1:0] in_empty;
    logic  [N_IN-1:0] in_rd_en;
    flit_t            out_flit;
    logic             out_valid;
    logic             credit_in;
    logic  [CW-1:0]   credit_count;
    logic  [GW-1:0]   grant_idx;
    logic             credit_err;

    modport master (
        input  in_flit, in_empty, credit_in,
        output in_rd_en, out_flit, out_valid, credit_count, grant_idx, credit_err
    );

    modport slave (
        output in_flit, in_empty, credit_in,
        input  in_rd_en, out_flit, out_valid, credit_count, grant_idx, credit_err
    );
endinterface

// File: rtl/mesh_output_arbiter.sv
// Mesh router output port: round-robin pop from the input FIFOs, registered output link,
// and a credit counter that keeps the downstream input FIFO from being overrun.
module mesh_output_arbiter #(
    parameter int N_IN    = 5,
    parameter int CREDITS = 8,
    parameter int FLIT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mesh_output_arbiter_if.master link
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int GW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]   req;
    logic              grant;
    logic [GW-1:0]     win;
    logic [GW-1:0]     ptr;
    logic [CW-1:0]     credit_q;
    logic              credit_err_q;
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic [GW-1:0]     grant_idx_q;

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N_IN) sum = sum - N_IN;
        return GW'(sum);
    endfunction

    assign req = ~link.in_empty;

    // Only the registered credit count gates a grant, so a same-cycle credit_in cannot pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
        grant = 1'b0;
        win   = '0;
        if (credit_q != '0) begin
            for (int k = 0; k < N_IN; k++) begin
                if (!grant && req[wrap_add(ptr, k)]) begin
                    grant = 1'b1;
                    win   = wrap_add(ptr, k);
                end
            end
        end
    end

    // Pop is masked while reset is held so the FIFO keeps the flit the output stage drops.
    assign link.in_rd_en = (grant && reset) ? (N_IN'(1) << win) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            grant_idx_q  <= '0;
            ptr          <= '0;
            credit_q     <= CW'(CREDITS);
            credit_err_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            out_valid_q <= grant;
            if (grant) begin
                out_flit_q  <= link.in_flit[win];
                grant_idx_q <= win;
                ptr         <= (win == GW'(N_IN - 1)) ? '0 : win + 1'b1;
            end

            case ({grant, link.credit_in})
                2'b10:   credit_q <= credit_q - 1'b1;
                2'b01: begin
                    if (credit_q == CW'(CREDITS)) credit_err_q <= 1'b1;
                    else                          credit_q     <= credit_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign link.out_valid    = out_valid_q;
    assign link.out_flit     = out_flit_q;
    assign link.grant_idx    = grant_idx_q;
    assign link.credit_count = credit_q;
    assign link.credit_err   = credit_err_q;
endmodule

// File: tb/tb_mesh_output_arbiter.sv
// Bench for mesh_output_arbiter: scenario tasks plus a cycle model that pushes each expected
// flit at its grant cycle and pops it when the registered output appears.
module tb_mesh_output_arbiter;
    localparam int N  = 5;
    localparam int C  = 8;
    localparam int FW = 16;

    typedef struct packed {
        logic [2:0]    idx;
        logic [FW-1:0] flit;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mesh_output_arbiter_if #(.N_IN(N), .CREDITS(C), .FLIT_W(FW)) link ();

    mesh_output_arbiter #(.N_IN(N), .CREDITS(C), .FLIT_W(FW)) dut (
        .clk  (clk),
        .reset(reset),
        .link (link)
    );

    always #5 clk = ~clk;

    sb_t  sb[$];
    int   seq[N];
    int   delivered[N];
    int   pop_cnt = 0;
    int   out_cnt = 0;
    int   m_ptr, m_cnt, m_win;
    bit   m_err, m_grant;
    logic [N-1:0] exp_rd;

    function automatic logic [FW-1:0] make_flit(input int i, input int s);
        return {4'(i), 12'(s)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle model and scoreboard: checks at each falling edge, advances FIFO heads after pops.
    initial begin
        sb_t e;
        int  j;
        m_ptr = 0; m_cnt = C; m_err = 0; m_grant = 0; m_win = 0;
        forever begin
            @(negedge clk);
            m_grant = 0;
            if (!reset) begin
                total++;
                if (link.out_valid !== 1'b0 || link.in_rd_en !== '0 || link.credit_count !== 4'(C)) begin
                    bad++;
                    $display("FAIL mon_reset: valid=%b rd_en=%b count=%0d, want 0/0/%0d",
                             link.out_valid, link.in_rd_en, link.credit_count, C);
                end
                sb.delete();
                m_ptr = 0; m_cnt = C; m_err = 0;
                for (int i = 0; i < N; i++) delivered[i] = seq[i];
            end else begin
                total++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    if (link.out_valid !== 1'b1 || link.grant_idx !== e.idx || link.out_flit !== e.flit) begin
                        bad++;
                        $display("FAIL mon_out: valid=%b idx=%0d flit=%h, want 1/%0d/%h",
                                 link.out_valid, link.grant_idx, link.out_flit, e.idx, e.flit);
                    end
                    if (link.out_valid === 1'b1) begin
                        out_cnt++;
                        delivered[e.idx]++;
                    end
                end else if (link.out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL mon_idle: out_valid=%b, want 0", link.out_valid);
                end
                total++;
                if (link.credit_count !== 4'(m_cnt) || link.credit_err !== m_err) begin
                    bad++;
                    $display("FAIL mon_credit: count=%0d err=%b, want %0d/%b",
                             link.credit_count, link.credit_err, m_cnt, m_err);
                end
                if (m_cnt != 0) begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        if (!m_grant && !link.in_empty[j]) begin
                            m_grant = 1;
                            m_win   = j;
                        end
                    end
                end
                exp_rd = m_grant ? (N'(1) << m_win) : '0;
                total++;
                if (link.in_rd_en !== exp_rd) begin
                    bad++;
                    $display("FAIL mon_rd_en: got=%b want=%b", link.in_rd_en, exp_rd);
                end
                if (m_grant) begin
                    sb.push_back('{idx: 3'(m_win), flit: make_flit(m_win, seq[m_win])});
                    m_ptr = (m_win + 1) % N;
                end
                if (m_grant && !link.credit_in) m_cnt--;
                else if (!m_grant && link.credit_in) begin
                    if (m_cnt == C) m_err = 1;
                    else            m_cnt++;
                end
            end
            @(posedge clk);
            #1;
            if (m_grant) begin
                seq[m_win]++;
                pop_cnt++;
                link.in_flit[m_win] = make_flit(m_win, seq[m_win]);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        link.in_empty  = '1;
        link.credit_in = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        link.in_empty  = '1;
        link.credit_in = 1'b0;
        @(negedge clk);
        total++;
        if (link.out_valid !== 1'b0 || link.out_flit !== '0 || link.grant_idx !== '0 ||
            link.credit_count !== 4'(C) || link.credit_err !== 1'b0 || link.in_rd_en !== '0) begin
            bad++;
            $display("FAIL reset_values: valid=%b flit=%h idx=%0d count=%0d err=%b rd_en=%b",
                     link.out_valid, link.out_flit, link.grant_idx, link.credit_count,
                     link.credit_err, link.in_rd_en);
        end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (link.in_rd_en !== '0 || link.out_valid !== 1'b0 || link.credit_count !== 4'(C)) begin
                bad++;
                $display("FAIL idle_empty: rd_en=%b valid=%b count=%0d, want 0/0/%0d",
                         link.in_rd_en, link.out_valid, link.credit_count, C);
            end
            next_cycle();
        end
    endtask

    task automatic test_two_inputs();
        int exp_idx;
        link.in_empty  = ~5'b01010;
        link.credit_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_idx = (c % 2 == 0) ? 1 : 3;
            @(negedge clk);
            total++;
            if (link.in_rd_en !== (5'b1 << exp_idx)) begin
                bad++;
                $display("FAIL rr_two: cycle %0d rd_en=%b want=%b", c, link.in_rd_en, 5'b1 << exp_idx);
            end
            if (c > 0) begin
                total++;
                if (link.out_valid !== 1'b1 || link.grant_idx !== 3'(4 - exp_idx)) begin
                    bad++;
                    $display("FAIL rr_two_out: cycle %0d valid=%b idx=%0d want 1/%0d",
                             c, link.out_valid, link.grant_idx, 4 - exp_idx);
                end
            end
            next_cycle();
        end
        link.in_empty  = '1;
        link.credit_in = 1'b0;
        next_cycle();
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        link.in_empty = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (link.in_rd_en !== (5'b1 << (c % 5))) begin
                bad++;
                $display("FAIL exhaust_seq: grant %0d rd_en=%b want=%b", c, link.in_rd_en, 5'b1 << (c % 5));
            end
            next_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (link.in_rd_en !== '0 || link.credit_count !== '0) begin
                bad++;
                $display("FAIL exhaust_stop: rd_en=%b count=%0d want 0/0", link.in_rd_en, link.credit_count);
            end
            next_cycle();
        end
        link.credit_in = 1'b1;
        @(negedge clk);
        total++;
        if (link.in_rd_en !== '0) begin
            bad++;
            $display("FAIL credit_same_cycle: rd_en=%b want 00000", link.in_rd_en);
        end
        next_cycle();
        link.credit_in = 1'b0;
        @(negedge clk);
        total++;
        if (link.in_rd_en !== 5'b01000 || link.credit_count !== 4'd1) begin
            bad++;
            $display("FAIL one_credit: rd_en=%b count=%0d want 01000/1", link.in_rd_en, link.credit_count);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (link.in_rd_en !== '0 || link.out_valid !== 1'b1 || link.grant_idx !== 3'd3) begin
            bad++;
            $display("FAIL one_credit_out: rd_en=%b valid=%b idx=%0d want 0/1/3",
                     link.in_rd_en, link.out_valid, link.grant_idx);
        end
        next_cycle();
        link.in_empty  = '1;
        link.credit_in = 1'b1;
        for (int c = 0; c < C; c++) next_cycle();
        link.credit_in = 1'b0;
    endtask

    task automatic test_credit_sat();
        link.in_empty = 5'b11110;
        for (int c = 0; c < 4; c++) next_cycle();
        link.credit_in = 1'b1;
        @(negedge clk);
        total++;
        if (link.credit_count !== 4'd4 || link.in_rd_en !== 5'b00001) begin
            bad++;
            $display("FAIL both_pre: count=%0d rd_en=%b want 4/00001", link.credit_count, link.in_rd_en);
        end
        next_cycle();
        link.in_empty = '1;
        @(negedge clk);
        total++;
        if (link.credit_count !== 4'd4) begin
            bad++;
            $display("FAIL both_post: count=%0d want 4", link.credit_count);
        end
        for (int c = 0; c < 4; c++) next_cycle();
        @(negedge clk);
        total++;
        if (link.credit_count !== 4'(C) || link.credit_err !== 1'b0) begin
            bad++;
            $display("FAIL sat_pre: count=%0d err=%b want %0d/0", link.credit_count, link.credit_err, C);
        end
        next_cycle();
        link.credit_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (link.credit_count !== 4'(C) || link.credit_err !== 1'b1) begin
                bad++;
                $display("FAIL sat_sticky: count=%0d err=%b want %0d/1", link.credit_count, link.credit_err, C);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        link.in_empty = '0;
        for (int c = 0; c < 6; c++) next_cycle();
        total++;
        if (link.out_valid !== 1'b1 || link.credit_count !== 4'd2) begin
            bad++;
            $display("FAIL mid_pre: valid=%b count=%0d want 1/2", link.out_valid, link.credit_count);
        end
        reset = 1'b0;
        #1;
        total++;
        if (link.out_valid !== 1'b0 || link.in_rd_en !== '0 || link.credit_count !== 4'(C)) begin
            bad++;
            $display("FAIL mid_async: valid=%b rd_en=%b count=%0d want 0/0/%0d",
                     link.out_valid, link.in_rd_en, link.credit_count, C);
        end
        next_cycle();
        reset = 1'b1;
        link.in_empty = 5'b00011;
        @(negedge clk);
        total++;
        if (link.in_rd_en !== 5'b00100 || link.credit_count !== 4'(C)) begin
            bad++;
            $display("FAIL mid_release: rd_en=%b count=%0d want 00100/%0d", link.in_rd_en, link.credit_count, C);
        end
        next_cycle();
        link.in_empty = '1;
        next_cycle();
    endtask

    task automatic test_out_flit();
        int p0, o0;
        do_reset();
        p0 = pop_cnt;
        o0 = out_cnt;
        for (int c = 0; c < 300; c++) begin
            link.in_empty  = N'($urandom);
            link.credit_in = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        link.in_empty  = '1;
        link.credit_in = 1'b0;
        for (int c = 0; c < 3; c++) next_cycle();
        total++;
        if (pop_cnt - p0 == 0 || pop_cnt - p0 != out_cnt - o0) begin
            bad++;
            $display("FAIL flit_count: outputs=%0d want pops=%0d (nonzero)", out_cnt - o0, pop_cnt - p0);
        end
    endtask

    initial begin
        reset          = 1'b0;
        link.in_empty  = '1;
        link.credit_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]          = 0;
            delivered[i]    = 0;
            link.in_flit[i] = make_flit(i, 0);
        end
        test_reset();
        test_two_inputs();
        test_credit_exhaust();
        test_credit_sat();
        test_reset_midstream();
        test_out_flit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
